range_sample_framer: RTL and testbench

Upstream feeder for the range finder. Accepts a byte-wide stream with valid/ready and end-of-frame marking, and assembles little-endian WIDTH-bit samples. It drives the range finder's sample, `go` and `finish` inputs so that each frame becomes exactly one RUN interval, and the range finder's ERROR state is never entered. Malformed frames (a trailing partial sample) are detected and flagged.

---
 rtl/range_sample_framer.sv | 128 ++++++++++++
 tb/tb_range_sample_framer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/range_sample_framer.sv
// range_sample_framer: packs a valid/ready byte stream into little-endian
// WIDTH-bit samples. It drives the range finder's go/finish so that each
// frame maps to exactly one RUN interval. A frame that ends part-way through
// a sample is flagged with frame_error.
module range_sample_framer #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  input  logic             byte_last,
  output logic             byte_ready,
  output logic [WIDTH-1:0] sample_out,
  output logic             go,
  output logic             finish,
  output logic             frame_error
);

  localparam int BYTES  = WIDTH / 8;
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSEMBLE,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [BIDX_W-1:0]  r_bidx;
  logic               r_open;
  logic [WIDTH-1:0]   r_shadow;
  logic [WIDTH-1:0]   w_full;
  logic [WIDTH-1:0]   r_sample;
  logic               r_go;
  logic               r_finish;
  logic               r_ferr;
  logic               r_ready;
  logic               w_xfer;

  assign w_xfer = byte_valid && r_ready;

  // Next-state logic: a last byte always leads through DRAIN and FIN.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_ASSEMBLE: begin
        if (w_xfer) begin
          w_next = byte_last ? S_DRAIN : S_ASSEMBLE;
        end
      end
      S_DRAIN: w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Full sample = bytes gathered so far plus the byte completing it.
  always_comb begin
    w_full = r_shadow;
    w_full[WIDTH-1 -: 8] = byte_in;
  end

  // Shadow byte lanes; pure data, so no reset needed.
  always_ff @(posedge clock) begin
    if (w_xfer) begin
      for (int i = 0; i < BYTES; i++) begin
        if (r_bidx == BIDX_W'(i)) begin
          r_shadow[8*i +: 8] <= byte_in;
        end
      end
    end
  end

  // State, byte index, frame-open flag and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_bidx   <= '0;
      r_open   <= 1'b0;
      r_sample <= '0;
      r_go     <= 1'b0;
      r_finish <= 1'b0;
      r_ferr   <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_state  <= w_next;
      // Ready is registered from the next state so it never depends on inputs.
      r_ready  <= (w_next == S_IDLE) || (w_next == S_ASSEMBLE);
      r_go     <= 1'b0;
      r_finish <= 1'b0;
      r_ferr   <= 1'b0;
      if (w_xfer) begin
        if (r_bidx == LAST_IDX) begin
          r_bidx   <= '0;
          r_sample <= w_full;
          if (!r_open) begin
            r_go   <= 1'b1;
            r_open <= 1'b1;
          end
        end else if (byte_last) begin
          // Trailing partial sample: drop it, keep sample_out as is.
          r_bidx <= '0;
          r_ferr <= 1'b1;
        end else begin
          r_bidx <= r_bidx + 1'b1;
        end
      end
      // finish only closes a RUN that go actually opened.
      if (r_state == S_DRAIN) begin
        r_finish <= r_open;
      end
      if (r_state == S_FIN) begin
        r_open <= 1'b0;
      end
    end
  end

  assign byte_ready  = r_ready;
  assign sample_out  = r_sample;
  assign go          = r_go;
  assign finish      = r_finish;
  assign frame_error = r_ferr;

endmodule

// File: tb/tb_range_sample_framer.sv
// Testbench for range_sample_framer (WIDTH=16): directed scenarios plus
// randomized frames, all checked against a frame-level reference model.
module tb_range_sample_framer;

  localparam int WIDTH = 16;
  localparam int BYTES = WIDTH / 8;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [7:0]       byte_in = 8'h00;
  logic             byte_valid = 1'b0;
  logic             byte_last = 1'b0;
  logic             byte_ready;
  logic [WIDTH-1:0] sample_out;
  logic             go;
  logic             finish;
  logic             frame_error;

  range_sample_framer #(.WIDTH(WIDTH)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_last   (byte_last),
    .byte_ready  (byte_ready),
    .sample_out  (sample_out),
    .go          (go),
    .finish      (finish),
    .frame_error (frame_error)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int obs_go  = 0;
  int obs_fin = 0;
  int obs_err = 0;

  // Reference model: expected outputs for the current cycle plus frame state.
  logic [7:0]       m_frame[$];
  logic [WIDTH-1:0] m_sample = '0;
  logic             m_ready = 1'b1;
  logic             m_go = 1'b0;
  logic             m_fin = 1'b0;
  logic             m_err = 1'b0;
  logic             m_acc = 1'b0;
  logic             m_fin_flag = 1'b0;
  int               m_gap = 0;

  task automatic model_reset();
    m_frame.delete();
    m_sample   = '0;
    m_ready    = 1'b1;
    m_go       = 1'b0;
    m_fin      = 1'b0;
    m_err      = 1'b0;
    m_acc      = 1'b0;
    m_fin_flag = 1'b0;
    m_gap      = 0;
  endtask

  // One cycle: compare DUT with the model at the falling edge, then drive
  // the inputs for the coming rising edge and advance the model.
  task automatic tick(input logic v, input logic [7:0] b, input logic l);
    logic ngo, nerr, nfin;
    @(negedge clock);
    n_tests++;
    if (byte_ready !== m_ready) begin
      n_fail++;
      $display("FAIL byte_ready @%0t: got %b expected %b", $time, byte_ready, m_ready);
    end
    n_tests++;
    if (sample_out !== m_sample) begin
      n_fail++;
      $display("FAIL sample_out @%0t: got %h expected %h", $time, sample_out, m_sample);
    end
    n_tests++;
    if (go !== m_go) begin
      n_fail++;
      $display("FAIL go @%0t: got %b expected %b", $time, go, m_go);
    end
    n_tests++;
    if (finish !== m_fin) begin
      n_fail++;
      $display("FAIL finish @%0t: got %b expected %b", $time, finish, m_fin);
    end
    n_tests++;
    if (frame_error !== m_err) begin
      n_fail++;
      $display("FAIL frame_error @%0t: got %b expected %b", $time, frame_error, m_err);
    end
    if (go === 1'b1) obs_go++;
    if (finish === 1'b1) obs_fin++;
    if (frame_error === 1'b1) obs_err++;

    byte_valid = v;
    byte_in    = b;
    byte_last  = l;

    ngo = 1'b0; nerr = 1'b0; nfin = 1'b0;
    if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 1) nfin = m_fin_flag;
    end
    m_acc = v && m_ready;
    if (m_acc) begin
      m_frame.push_back(b);
      if (m_frame.size() % BYTES == 0) begin
        for (int k = 0; k < BYTES; k++)
          m_sample[8*k +: 8] = m_frame[m_frame.size() - BYTES + k];
        if (m_frame.size() == BYTES) ngo = 1'b1;
      end
      if (l) begin
        if (m_frame.size() % BYTES != 0) nerr = 1'b1;
        m_fin_flag = (m_frame.size() >= BYTES);
        m_gap = 2;
        m_frame.delete();
      end
    end
    m_ready = (m_gap == 0);
    m_go    = ngo;
    m_fin   = nfin;
    m_err   = nerr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    byte_valid = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    @(negedge clock);
    n_tests++;
    if (byte_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", byte_ready); end
    n_tests++;
    if (sample_out !== '0) begin n_fail++; $display("FAIL reset_sample: got %h expected 0", sample_out); end
    n_tests++;
    if ({go, finish, frame_error} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pulses: got %b expected 000", {go, finish, frame_error});
    end
    idle(2);
  endtask

  task automatic test_normal();
    logic [7:0] bytes[6] = '{8'h34, 8'h12, 8'h05, 8'h00, 8'hFF, 8'h00};
    int g0 = obs_go, f0 = obs_fin, e0 = obs_err;
    for (int i = 0; i < 6; i++) tick(1'b1, bytes[i], (i == 5));
    idle(3);
    n_tests++;
    if (sample_out !== 16'h00FF) begin n_fail++; $display("FAIL normal_sample: got %h expected 00ff", sample_out); end
    n_tests++;
    if ((obs_go - g0) != 1 || (obs_fin - f0) != 1 || (obs_err - e0) != 0) begin
      n_fail++; $display("FAIL normal_pulses: got go=%0d fin=%0d err=%0d expected 1 1 0",
                         obs_go - g0, obs_fin - f0, obs_err - e0);
    end
  endtask

  task automatic test_single();
    int g0 = obs_go, f0 = obs_fin;
    tick(1'b1, 8'hCD, 1'b0);
    tick(1'b1, 8'hAB, 1'b1);
    idle(3);
    n_tests++;
    if (sample_out !== 16'hABCD) begin n_fail++; $display("FAIL single_sample: got %h expected abcd", sample_out); end
    n_tests++;
    if ((obs_go - g0) != 1 || (obs_fin - f0) != 1) begin
      n_fail++; $display("FAIL single_pulses: got go=%0d fin=%0d expected 1 1", obs_go - g0, obs_fin - f0);
    end
  endtask

  task automatic test_partial_open();
    int g0 = obs_go, f0 = obs_fin, e0 = obs_err;
    tick(1'b1, 8'h01, 1'b0);
    tick(1'b1, 8'h00, 1'b0);
    tick(1'b1, 8'h07, 1'b1);
    idle(3);
    n_tests++;
    if (sample_out !== 16'h0001) begin n_fail++; $display("FAIL partial_open_sample: got %h expected 0001", sample_out); end
    n_tests++;
    if ((obs_go - g0) != 1 || (obs_fin - f0) != 1 || (obs_err - e0) != 1) begin
      n_fail++; $display("FAIL partial_open_pulses: got go=%0d fin=%0d err=%0d expected 1 1 1",
                         obs_go - g0, obs_fin - f0, obs_err - e0);
    end
  endtask

  task automatic test_partial_empty();
    int g0 = obs_go, f0 = obs_fin, e0 = obs_err;
    tick(1'b1, 8'h07, 1'b1);
    idle(3);
    n_tests++;
    if (byte_ready !== 1'b1) begin n_fail++; $display("FAIL partial_empty_ready: got %b expected 1", byte_ready); end
    n_tests++;
    if ((obs_go - g0) != 0 || (obs_fin - f0) != 0 || (obs_err - e0) != 1) begin
      n_fail++; $display("FAIL partial_empty_pulses: got go=%0d fin=%0d err=%0d expected 0 0 1",
                         obs_go - g0, obs_fin - f0, obs_err - e0);
    end
  endtask

  // Next byte held valid through DRAIN/FIN; it must transfer exactly once.
  task automatic test_back_to_back();
    int e0 = obs_err, f0 = obs_fin;
    tick(1'b1, 8'hCD, 1'b0);
    tick(1'b1, 8'hAB, 1'b1);
    tick(1'b1, 8'h55, 1'b1);
    tick(1'b1, 8'h55, 1'b1);
    tick(1'b1, 8'h55, 1'b1);
    idle(4);
    n_tests++;
    if ((obs_err - e0) != 1 || (obs_fin - f0) != 1) begin
      n_fail++; $display("FAIL back_to_back_pulses: got err=%0d fin=%0d expected 1 1", obs_err - e0, obs_fin - f0);
    end
    n_tests++;
    if (sample_out !== 16'hABCD) begin n_fail++; $display("FAIL back_to_back_sample: got %h expected abcd", sample_out); end
  endtask

  // Asynchronous reset in the middle of an open frame's second sample.
  task automatic test_reset_mid();
    int f0;
    tick(1'b1, 8'h01, 1'b0);
    tick(1'b1, 8'h02, 1'b0);
    tick(1'b1, 8'h03, 1'b0);
    @(posedge clock);
    #2;
    byte_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (sample_out !== '0 || byte_ready !== 1'b1 || {go, finish, frame_error} !== 3'b000) begin
      n_fail++; $display("FAIL reset_mid: got sample=%h ready=%b pulses=%b expected 0000 1 000",
                         sample_out, byte_ready, {go, finish, frame_error});
    end
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    f0 = obs_fin;
    idle(5);
    n_tests++;
    if ((obs_fin - f0) != 0) begin n_fail++; $display("FAIL reset_mid_finish: got %0d expected 0", obs_fin - f0); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 40; f++) begin
      int len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) begin
        logic [7:0] b = 8'($urandom);
        int tries = 0;
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        do begin
          tick(1'b1, b, (i == len - 1));
          tries++;
        end while (!m_acc && tries < 10);
        if (!m_acc) begin
          n_tests++; n_fail++;
          $display("FAIL random_accept: byte not accepted within %0d cycles", tries);
        end
      end
      if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 3));
    end
    idle(4);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_single();
    test_partial_open();
    test_partial_empty();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
